// File: rtl/alu_pkg.sv
// ---- alu_pkg: shared ALU opcodes and mult/div sequencer state encoding | rev 1.0 ----
`default_nettype none

package alu_pkg;

  localparam logic [3:0] ALU_OP_AND  = 4'b0000;
  localparam logic [3:0] ALU_OP_OR   = 4'b0001;
  localparam logic [3:0] ALU_OP_ADD  = 4'b0010;
  localparam logic [3:0] ALU_OP_XOR  = 4'b0100;
  localparam logic [3:0] ALU_OP_MULT = 4'b0101;
  localparam logic [3:0] ALU_OP_SUB  = 4'b0110;
  localparam logic [3:0] ALU_OP_SLT  = 4'b0111;
  localparam logic [3:0] ALU_OP_SLL  = 4'b1000;
  localparam logic [3:0] ALU_OP_SRL  = 4'b1001;
  localparam logic [3:0] ALU_OP_SRA  = 4'b1010;
  localparam logic [3:0] ALU_OP_DIV  = 4'b1011;
  localparam logic [3:0] ALU_OP_NOR  = 4'b1100;

  localparam int         STATE_W = 2;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

endpackage

`default_nettype wire

// File: rtl/muldiv_step.sv
// ---- muldiv_step: one radix-2 shift-add (mult) or restoring-subtract (div) iteration | rev 1.0 ----
`default_nettype none

module muldiv_step
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 mode,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]     operand,
  output logic [2*WIDTH-1:0]   acc_next
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_rem_sh;
  logic [WIDTH:0] w_trial;

  always_comb begin
    w_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
    w_rem_sh = acc[2*WIDTH-1:WIDTH-1];
    w_trial  = w_rem_sh - {1'b0, operand};
    acc_next = '0;
    if (mode == MODE_DIV) begin
      // Shifted remainder is always below 2*divisor, so the top bit of trial is a clean sign.
      if (!w_trial[WIDTH]) begin
        acc_next = {w_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {w_rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end else if (acc[0]) begin
      acc_next = {w_sum, acc[WIDTH-1:1]};
    end else begin
      acc_next = {1'b0, acc[2*WIDTH-1:1]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/muldiv_sequencer.sv
// ---- muldiv_sequencer: iterative unsigned mult/div unit for the EX stage | rev 1.0 ----
`default_nettype none

module muldiv_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3:0]        alu_control,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic              stall,
  output logic [WIDTH-1:0]  hi,
  output logic [WIDTH-1:0]  lo,
  output logic [WIDTH-1:0]  result
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  logic [STATE_W-1:0]  r_state;
  logic [STATE_W-1:0]  w_state_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [2*WIDTH-1:0]  r_acc;
  logic [WIDTH-1:0]    r_operand;
  logic [2*WIDTH-1:0]  w_step_next;
  logic                w_is_mul;
  logic                w_is_div;
  logic                w_accept;
  logic                w_last;

  assign w_is_mul = (alu_control == ALU_OP_MULT);
  assign w_is_div = (alu_control == ALU_OP_DIV);
  assign w_accept = rst_n & start & (r_state == ST_IDLE) & (w_is_mul | w_is_div) & ~flush;
  assign w_last   = (r_cnt == C_LAST);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .mode     ((r_state == ST_DIV) ? MODE_DIV : MODE_MUL),
    .acc      (r_acc),
    .operand  (r_operand),
    .acc_next (w_step_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_is_mul)       w_state_next = ST_MUL;
          else if (b == '0)   w_state_next = ST_DONE;
          else                w_state_next = ST_DIV;
        end
      end
      ST_MUL, ST_DIV: begin
        if (flush)       w_state_next = ST_IDLE;
        else if (w_last) w_state_next = ST_DONE;
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy  = (r_state == ST_MUL) || (r_state == ST_DIV);
    done  = (r_state == ST_DONE);
    stall = busy | w_accept;
  end

  // Datapath: operands latched on accept, results committed only when entering DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_operand <= '0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_cnt <= '0;
            if (w_is_mul) begin
              r_acc     <= {{WIDTH{1'b0}}, b};
              r_operand <= a;
            end else if (b == '0) begin
              hi <= a;
              lo <= '1;
            end else begin
              r_acc     <= {{WIDTH{1'b0}}, a};
              r_operand <= b;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          if (!flush) begin
            r_acc <= w_step_next;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
              hi <= w_step_next[2*WIDTH-1:WIDTH];
              lo <= w_step_next[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign result = lo;

endmodule

`default_nettype wire
